// File: rtl/axi_reg_arb_pkg.sv
// axi_reg_arb_pkg: FSM state encoding and AXI response codes shared by the arbiter (no ports)
package axi_reg_arb_pkg;
  typedef enum logic [2:0] {IDLE, W_REQ, W_RESP, R_ADDR, R_DATA, RESP} arb_state_e;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: 2-way round-robin pick; in clk/areset/valid/accept, out one-hot grant and grant_idx
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       areset,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant,
  output logic       grant_idx
);
  logic last_grant;
  always_comb begin
    grant_idx = &valid ? ~last_grant : valid[1];
    grant = |valid ? (grant_idx ? 2'b10 : 2'b01) : 2'b00;
  end
  always_ff @(posedge clk)
    if (areset) last_grant <= 1'b1;
    else if (accept) last_grant <= grant_idx;
endmodule

// File: rtl/axi_reg_arbiter.sv
// axi_reg_arbiter: two requesters (valid/ready cmd + rsp) serialised onto one AXI master port (AW/W/B, AR/R)
module axi_reg_arbiter
  import axi_reg_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W = 4,
  parameter int N_REGS = 8,
  parameter int ID_BASE = 0
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic [1:0]             req_valid_i,
  output logic [1:0]             req_ready_o,
  input  logic [1:0]             req_we_i,
  input  logic [1:0][ADDR_W-1:0] req_addr_i,
  input  logic [1:0][DATA_W-1:0] req_wdata_i,
  input  logic [1:0][3:0]        req_wstrb_i,
  output logic [1:0]             rsp_valid_o,
  input  logic [1:0]             rsp_ready_i,
  output logic [DATA_W-1:0]      rsp_rdata_o,
  output logic [1:0]             rsp_resp_o,
  output logic [ID_W-1:0]        awid_o,
  output logic [ADDR_W-1:0]      awaddr_o,
  output logic                   awvalid_o,
  input  logic                   awready_i,
  output logic [ID_W-1:0]        wid_o,
  output logic [DATA_W-1:0]      wdata_o,
  output logic [3:0]             wstrb_o,
  output logic                   wlast_o,
  output logic                   wvalid_o,
  input  logic                   wready_i,
  input  logic [ID_W-1:0]        bid_i,
  input  logic [1:0]             bresp_i,
  input  logic                   bvalid_i,
  output logic                   bready_o,
  output logic [ID_W-1:0]        arid_o,
  output logic [ADDR_W-1:0]      araddr_o,
  output logic                   arvalid_o,
  input  logic                   arready_i,
  input  logic [ID_W-1:0]        rid_i,
  input  logic [DATA_W-1:0]      rdata_i,
  input  logic                   rlast_i,
  input  logic                   rvalid_i,
  output logic                   rready_o
);
  arb_state_e state, state_nx;
  logic owner, gidx, accept, oor, aw_done, w_done, aw_hs, w_hs, unused_rlast;
  logic [1:0] gnt, resp;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata, rdata;
  logic [3:0] wstrb;
  logic [ID_W-1:0] id;
  rr_arbiter_2 u_rr (
    .clk(clk),
    .areset(areset),
    .valid(req_valid_i),
    .accept(accept),
    .grant(gnt),
    .grant_idx(gidx)
  );
  assign accept = state == IDLE && |req_valid_i;
  assign oor = req_addr_i[gidx] >= ADDR_W'(N_REGS);
  assign id = ID_W'(ID_BASE) + ID_W'(owner);
  assign req_ready_o = state == IDLE ? gnt : 2'b00;
  assign awvalid_o = state == W_REQ && !aw_done;
  assign wvalid_o = state == W_REQ && !w_done;
  assign bready_o = state == W_RESP;
  assign arvalid_o = state == R_ADDR;
  assign rready_o = state == R_DATA;
  assign rsp_valid_o = state == RESP ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign awid_o = id;
  assign wid_o = id;
  assign arid_o = id;
  assign awaddr_o = addr;
  assign araddr_o = addr;
  assign wdata_o = wdata;
  assign wstrb_o = wstrb;
  assign wlast_o = 1'b1;
  assign rsp_rdata_o = rdata;
  assign rsp_resp_o = resp;
  assign aw_hs = awvalid_o & awready_i;
  assign w_hs = wvalid_o & wready_i;
  assign unused_rlast = rlast_i;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = !accept ? IDLE : oor ? RESP : req_we_i[gidx] ? W_REQ : R_ADDR;
      W_REQ:   state_nx = (aw_done | aw_hs) & (w_done | w_hs) ? W_RESP : W_REQ;
      W_RESP:  state_nx = bvalid_i ? RESP : W_RESP;
      R_ADDR:  state_nx = arready_i ? R_DATA : R_ADDR;
      R_DATA:  state_nx = rvalid_i ? RESP : R_DATA;
      RESP:    state_nx = rsp_ready_i[owner] ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (areset) begin
      state <= IDLE;
      owner <= 1'b0;
      addr <= '0;
      wdata <= '0;
      wstrb <= '0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      rdata <= '0;
      resp <= RESP_OKAY;
    end else begin
      state <= state_nx;
      if (accept) begin
        owner <= gidx;
        addr <= req_addr_i[gidx];
        wdata <= req_wdata_i[gidx];
        wstrb <= req_wstrb_i[gidx];
        aw_done <= 1'b0;
        w_done <= 1'b0;
        if (oor) begin
          rdata <= '0;
          resp <= RESP_SLVERR;
        end
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs) w_done <= 1'b1;
      if (state == W_RESP && bvalid_i) begin
        rdata <= '0;
        resp <= bid_i != id ? RESP_SLVERR : bresp_i;
      end
      if (state == R_DATA && rvalid_i) begin
        rdata <= rdata_i;
        resp <= rid_i != id ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end
endmodule

// File: tb/tb_axi_reg_arbiter.sv
// tb_axi_reg_arbiter: randomized bench with a behavioural AXI slave and a register-file response model
module tb_axi_reg_arbiter;
  localparam int IW = 4;
  localparam int NR = 8;
  logic clk = 1'b0;
  logic areset;
  logic [1:0] req_valid_i, req_ready_o, req_we_i, rsp_valid_o, rsp_ready_i, rsp_resp_o, bresp_i;
  logic [1:0][31:0] req_addr_i, req_wdata_i;
  logic [1:0][3:0] req_wstrb_i;
  logic [31:0] rsp_rdata_o, awaddr_o, wdata_o, araddr_o, rdata_i;
  logic [IW-1:0] awid_o, wid_o, arid_o, bid_i, rid_i;
  logic [3:0] wstrb_o;
  logic awvalid_o, awready_i, wlast_o, wvalid_o, wready_i, bvalid_i, bready_o;
  logic arvalid_o, arready_i, rlast_i, rvalid_i, rready_o;
  int n_chk, n_pass;
  logic [31:0] model [NR];
  logic [31:0] mem [NR];
  int aw_dly, w_dly, b_dly, ar_dly, r_dly;
  bit bad_id;
  int aw_cnt, w_cnt, ar_cnt, b_cnt, aw_hi, w_only, axi_viol;
  logic [IW-1:0] last_awid, last_arid;
  int lat;
  logic [31:0] rd;
  logic [1:0] rs;
  always #5 clk = ~clk;
  axi_reg_arbiter dut (
    .clk(clk), .areset(areset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o), .rsp_resp_o(rsp_resp_o),
    .awid_o(awid_o), .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wid_o(wid_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
    .arid_o(arid_o), .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rid_i(rid_i), .rdata_i(rdata_i), .rlast_i(rlast_i), .rvalid_i(rvalid_i), .rready_o(rready_o)
  );
  initial begin : slave
    bit got_aw, got_w, got_ar, hs_b, hs_r, pa, pw, par;
    int ca, cw, cb, car, cr;
    logic [31:0] a_aw, a_ar, wd;
    logic [3:0] ws;
    for (int i = 0; i < NR; i++) mem[i] = '0;
    awready_i = 0; wready_i = 0; bvalid_i = 0; bid_i = '0; bresp_i = '0;
    arready_i = 0; rvalid_i = 0; rid_i = '0; rdata_i = '0; rlast_i = 1;
    got_aw = 0; got_w = 0; got_ar = 0; hs_b = 0; hs_r = 0; pa = 0; pw = 0; par = 0;
    ca = 0; cw = 0; cb = 0; car = 0; cr = 0; a_aw = '0; a_ar = '0; wd = '0; ws = '0;
    forever begin
      @(negedge clk);
      if (areset) begin
        awready_i = 0; wready_i = 0; bvalid_i = 0; arready_i = 0; rvalid_i = 0;
        got_aw = 0; got_w = 0; got_ar = 0; hs_b = 0; hs_r = 0; pa = 0; pw = 0; par = 0;
        ca = 0; cw = 0; cb = 0; car = 0; cr = 0;
        continue;
      end
      if ((pa && !awvalid_o) || (pw && !wvalid_o) || (par && !arvalid_o)) axi_viol++;
      if (hs_b) bvalid_i = 0;
      if (hs_r) rvalid_i = 0;
      if (got_aw && got_w && !bvalid_i) begin
        if (cb >= b_dly) begin
          for (int i = 0; i < 4; i++) if (ws[i]) mem[a_aw[2:0]][8*i +: 8] = wd[8*i +: 8];
          bvalid_i = 1; bid_i = last_awid ^ IW'(bad_id); bresp_i = 2'b00;
          got_aw = 0; got_w = 0; cb = 0;
        end else cb++;
      end
      if (got_ar && !rvalid_i) begin
        if (cr >= r_dly) begin
          rvalid_i = 1; rdata_i = mem[a_ar[2:0]]; rid_i = last_arid ^ IW'(bad_id);
          got_ar = 0; cr = 0;
        end else cr++;
      end
      if (awvalid_o && !got_aw) begin awready_i = ca >= aw_dly; ca++; end else begin awready_i = 0; ca = 0; end
      if (wvalid_o && !got_w) begin wready_i = cw >= w_dly; cw++; end else begin wready_i = 0; cw = 0; end
      if (arvalid_o && !got_ar) begin arready_i = car >= ar_dly; car++; end else begin arready_i = 0; car = 0; end
      aw_hi += int'(awvalid_o);
      w_only += int'(!awvalid_o && wvalid_o);
      if (awvalid_o && awready_i) begin got_aw = 1; a_aw = awaddr_o; last_awid = awid_o; aw_cnt++; ca = 0; end
      if (wvalid_o && wready_i) begin got_w = 1; wd = wdata_o; ws = wstrb_o; w_cnt++; cw = 0; end
      if (arvalid_o && arready_i) begin got_ar = 1; a_ar = araddr_o; last_arid = arid_o; ar_cnt++; car = 0; end
      hs_b = bvalid_i && bready_o;
      if (hs_b) b_cnt++;
      hs_r = rvalid_i && rready_o;
      pa = awvalid_o && !awready_i;
      pw = wvalid_o && !wready_i;
      par = arvalid_o && !arready_i;
    end
  end
  task automatic run_cmd(input int k, input bit we, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int hold,
                         output int l, output logic [31:0] r, output logic [1:0] c);
    int t;
    l = -1; r = '0; c = 2'b11;
    @(negedge clk);
    req_we_i[k] = we; req_addr_i[k] = a; req_wdata_i[k] = d; req_wstrb_i[k] = s; req_valid_i[k] = 1'b1;
    #1;
    t = 0;
    while (!req_ready_o[k] && t < 100) begin @(negedge clk); #1; t++; end
    if (!req_ready_o[k]) begin req_valid_i[k] = 1'b0; return; end
    t = 0;
    do begin @(negedge clk); req_valid_i[k] = 1'b0; t++; end while (!rsp_valid_o[k] && t < 200);
    if (!rsp_valid_o[k]) return;
    l = t; r = rsp_rdata_o; c = rsp_resp_o;
    repeat (hold) @(negedge clk);
    rsp_ready_i[k] = 1'b1;
    @(negedge clk);
    rsp_ready_i[k] = 1'b0;
  endtask
  task automatic apply_reset;
    @(negedge clk);
    areset = 1; req_valid_i = '0; rsp_ready_i = '0;
    repeat (2) @(negedge clk);
    areset = 0;
  endtask
  task automatic test_reset;
    @(negedge clk);
    areset = 1;
    repeat (2) @(negedge clk);
    n_chk++; if ({awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o, rsp_valid_o} !== 7'b0) $display("FAIL reset_valids_in_reset: got %b expected 0", {awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o, rsp_valid_o}); else n_pass++;
    areset = 0;
    @(negedge clk); #1;
    n_chk++; if ({awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o, rsp_valid_o, req_ready_o} !== 9'b0) $display("FAIL reset_valids: got %b expected 0", {awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o, rsp_valid_o, req_ready_o}); else n_pass++;
    n_chk++; if ({awaddr_o, araddr_o, wdata_o, wstrb_o} !== 100'b0) $display("FAIL reset_payload: got %h %h %h %h expected 0", awaddr_o, araddr_o, wdata_o, wstrb_o); else n_pass++;
    n_chk++; if ({rsp_rdata_o, rsp_resp_o, awid_o, wid_o, arid_o} !== 46'b0) $display("FAIL reset_rsp_ids: got %h %h %h %h %h expected 0", rsp_rdata_o, rsp_resp_o, awid_o, wid_o, arid_o); else n_pass++;
    n_chk++; if (wlast_o !== 1'b1) $display("FAIL wlast: got %b expected 1", wlast_o); else n_pass++;
  endtask
  task automatic test_write_read;
    int a0, w0;
    a0 = aw_cnt; w0 = w_cnt;
    run_cmd(0, 1, 32'd3, 32'hDEADBEEF, 4'hF, 0, lat, rd, rs);
    model[3] = 32'hDEADBEEF;
    n_chk++; if (lat !== 3) $display("FAIL wr_latency: got %0d expected 3", lat); else n_pass++;
    n_chk++; if (rs !== 2'b00 || rd !== 32'h0) $display("FAIL wr_rsp: got resp %b rdata %h expected 00 0", rs, rd); else n_pass++;
    n_chk++; if (aw_cnt - a0 !== 1 || w_cnt - w0 !== 1 || last_awid !== 4'd0) $display("FAIL wr_axi: got aw %0d w %0d id %0d expected 1 1 0", aw_cnt - a0, w_cnt - w0, last_awid); else n_pass++;
    run_cmd(0, 0, 32'd3, 32'h0, 4'h0, 0, lat, rd, rs);
    n_chk++; if (lat !== 3) $display("FAIL rd_latency: got %0d expected 3", lat); else n_pass++;
    n_chk++; if (rd !== model[3] || rs !== 2'b00) $display("FAIL rd_data: got %h/%b expected %h/00", rd, rs, model[3]); else n_pass++;
    n_chk++; if (last_arid !== 4'd0) $display("FAIL rd_id: got %0d expected 0", last_arid); else n_pass++;
  endtask
  task automatic test_arbitration;
    int g, t;
    bit last, exp_k;
    apply_reset;
    last = 1'b1;
    rsp_ready_i = 2'b11;
    req_we_i = 2'b00; req_addr_i[0] = 32'd1; req_addr_i[1] = 32'd2;
    req_valid_i = 2'b11;
    g = 0; t = 0;
    while (g < 4 && t < 100) begin
      #1;
      if (req_ready_o != 2'b00) begin
        exp_k = &req_valid_i ? !last : req_valid_i[1];
        last = exp_k;
        n_chk++; if (req_ready_o !== (exp_k ? 2'b10 : 2'b01)) $display("FAIL arb_grant%0d: got %b expected %b", g, req_ready_o, exp_k ? 2'b10 : 2'b01); else n_pass++;
        g++;
      end
      @(negedge clk);
      t++;
    end
    req_valid_i = 2'b00;
    n_chk++; if (g !== 4) $display("FAIL arb_count: got %0d grants expected 4", g); else n_pass++;
    repeat (8) @(negedge clk);
    rsp_ready_i = 2'b00;
  endtask
  task automatic test_out_of_range;
    int a0, r0;
    a0 = aw_cnt; r0 = ar_cnt;
    run_cmd(1, 0, 32'd8, 32'h0, 4'h0, 0, lat, rd, rs);
    n_chk++; if (lat !== 1) $display("FAIL oor_latency: got %0d expected 1", lat); else n_pass++;
    n_chk++; if (rs !== 2'b10 || rd !== 32'h0) $display("FAIL oor_rsp: got %b/%h expected 10/0", rs, rd); else n_pass++;
    run_cmd(0, 1, 32'hFFFF_0000, 32'h1234, 4'hF, 1, lat, rd, rs);
    n_chk++; if (rs !== 2'b10 || lat !== 1) $display("FAIL oor_wr: got %b lat %0d expected 10 lat 1", rs, lat); else n_pass++;
    n_chk++; if (aw_cnt !== a0 || ar_cnt !== r0) $display("FAIL oor_no_axi: got aw %0d ar %0d expected %0d %0d", aw_cnt, ar_cnt, a0, r0); else n_pass++;
  endtask
  task automatic test_wready_stall;
    int b0;
    w_dly = 6; aw_hi = 0; w_only = 0; b0 = b_cnt;
    run_cmd(0, 1, 32'd2, 32'hA5A5_5A5A, 4'hF, 0, lat, rd, rs);
    model[2] = 32'hA5A5_5A5A;
    w_dly = 0;
    n_chk++; if (aw_hi !== 1) $display("FAIL stall_aw_cycles: got %0d expected 1", aw_hi); else n_pass++;
    n_chk++; if (w_only !== 6) $display("FAIL stall_w_only_cycles: got %0d expected 6", w_only); else n_pass++;
    n_chk++; if (b_cnt - b0 !== 1) $display("FAIL stall_b_count: got %0d expected 1", b_cnt - b0); else n_pass++;
    n_chk++; if (lat !== 9 || rs !== 2'b00) $display("FAIL stall_rsp: got lat %0d resp %b expected 9 00", lat, rs); else n_pass++;
  endtask
  task automatic test_rsp_stall;
    int t, bad;
    @(negedge clk);
    req_we_i[0] = 0; req_addr_i[0] = 32'd3; req_valid_i[0] = 1'b1;
    #1;
    t = 0;
    while (!req_ready_o[0] && t < 50) begin @(negedge clk); #1; t++; end
    n_chk++; if (req_ready_o !== 2'b01) $display("FAIL hold_grant0: got %b expected 01", req_ready_o); else n_pass++;
    @(negedge clk);
    req_valid_i[0] = 1'b0; req_we_i[1] = 0; req_addr_i[1] = 32'd2; req_valid_i[1] = 1'b1;
    t = 0;
    while (!rsp_valid_o[0] && t < 50) begin @(negedge clk); t++; end
    bad = 0;
    repeat (4) begin
      @(negedge clk); #1;
      if (rsp_valid_o !== 2'b01 || rsp_rdata_o !== model[3] || rsp_resp_o !== 2'b00 || req_ready_o !== 2'b00) bad++;
    end
    n_chk++; if (bad !== 0) $display("FAIL hold_stable: got %0d unstable cycles expected 0 (rsp %b data %h)", bad, rsp_valid_o, rsp_rdata_o); else n_pass++;
    rsp_ready_i[0] = 1'b1;
    @(negedge clk);
    rsp_ready_i[0] = 1'b0;
    #1;
    n_chk++; if (rsp_valid_o !== 2'b00 || req_ready_o !== 2'b10) $display("FAIL hold_release: got rsp %b ready %b expected 00 10", rsp_valid_o, req_ready_o); else n_pass++;
    @(negedge clk);
    req_valid_i[1] = 1'b0;
    t = 0;
    while (!rsp_valid_o[1] && t < 50) begin @(negedge clk); t++; end
    n_chk++; if (rsp_valid_o !== 2'b10 || rsp_rdata_o !== model[2]) $display("FAIL hold_req1: got %b/%h expected 10/%h", rsp_valid_o, rsp_rdata_o, model[2]); else n_pass++;
    rsp_ready_i[1] = 1'b1;
    @(negedge clk);
    rsp_ready_i[1] = 1'b0;
    bad_id = 1;
    run_cmd(1, 1, 32'd5, 32'h0BAD_0B1D, 4'hF, 0, lat, rd, rs);
    model[5] = 32'h0BAD_0B1D;
    n_chk++; if (rs !== 2'b10) $display("FAIL bid_mismatch: got %b expected 10", rs); else n_pass++;
    run_cmd(0, 0, 32'd5, 32'h0, 4'h0, 0, lat, rd, rs);
    bad_id = 0;
    n_chk++; if (rs !== 2'b10 || rd !== model[5]) $display("FAIL rid_mismatch: got %b/%h expected 10/%h", rs, rd, model[5]); else n_pass++;
  endtask
  task automatic test_reset_mid;
    int t, seen;
    b_dly = 20;
    @(negedge clk);
    req_we_i[0] = 1; req_addr_i[0] = 32'd6; req_wdata_i[0] = 32'hCAFE_F00D; req_wstrb_i[0] = 4'hF; req_valid_i[0] = 1'b1;
    #1;
    t = 0;
    while (!req_ready_o[0] && t < 50) begin @(negedge clk); #1; t++; end
    @(negedge clk);
    req_valid_i[0] = 1'b0;
    t = 0;
    while (!bready_o && t < 20) begin @(negedge clk); t++; end
    n_chk++; if (bready_o !== 1'b1) $display("FAIL mid_reach_wresp: got %b expected 1", bready_o); else n_pass++;
    areset = 1;
    @(negedge clk); #1;
    n_chk++; if ({awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o, rsp_valid_o} !== 7'b0) $display("FAIL mid_reset_valids: got %b expected 0", {awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o, rsp_valid_o}); else n_pass++;
    @(negedge clk);
    areset = 0; b_dly = 0;
    seen = 0;
    repeat (5) begin @(negedge clk); if (rsp_valid_o !== 2'b00) seen++; end
    n_chk++; if (seen !== 0) $display("FAIL mid_no_rsp: got %0d rsp cycles expected 0", seen); else n_pass++;
    run_cmd(1, 0, 32'd3, 32'h0, 4'h0, 0, lat, rd, rs);
    n_chk++; if (lat !== 3 || rd !== model[3] || rs !== 2'b00 || last_arid !== 4'd1) $display("FAIL mid_after: got lat %0d %h/%b id %0d expected 3 %h/00 1", lat, rd, rs, last_arid, model[3]); else n_pass++;
  endtask
  task automatic test_random;
    int k, hold, a0, r0;
    bit we;
    logic [31:0] a, d, exp_rd;
    logic [3:0] s;
    logic [1:0] exp_rs;
    for (int i = 0; i < 40; i++) begin
      k = int'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1)); a = 32'($urandom_range(0, 9));
      d = $urandom; s = 4'($urandom_range(0, 15)); hold = int'($urandom_range(0, 2));
      aw_dly = int'($urandom_range(0, 3)); w_dly = int'($urandom_range(0, 3)); b_dly = int'($urandom_range(0, 3));
      ar_dly = int'($urandom_range(0, 3)); r_dly = int'($urandom_range(0, 3));
      a0 = aw_cnt; r0 = ar_cnt;
      exp_rs = a >= NR ? 2'b10 : 2'b00;
      exp_rd = (we || a >= NR) ? 32'h0 : model[a[2:0]];
      run_cmd(k, we, a, d, s, hold, lat, rd, rs);
      if (we && a < NR) for (int b = 0; b < 4; b++) if (s[b]) model[a[2:0]][8*b +: 8] = d[8*b +: 8];
      n_chk++; if (rs !== exp_rs || rd !== exp_rd) $display("FAIL rand%0d_rsp: req%0d we%0d addr %0d got %b/%h expected %b/%h", i, k, we, a, rs, rd, exp_rs, exp_rd); else n_pass++;
      if (a < NR) begin
        n_chk++; if ((we ? aw_cnt - a0 : ar_cnt - r0) !== 1 || (we ? last_awid : last_arid) !== IW'(k)) $display("FAIL rand%0d_axi: got count %0d id %0d expected 1 %0d", i, we ? aw_cnt - a0 : ar_cnt - r0, we ? last_awid : last_arid, k); else n_pass++;
      end else begin
        n_chk++; if (aw_cnt !== a0 || ar_cnt !== r0) $display("FAIL rand%0d_oor_axi: got aw %0d ar %0d expected none", i, aw_cnt - a0, ar_cnt - r0); else n_pass++;
      end
    end
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
    n_chk++; if (axi_viol !== 0) $display("FAIL axi_valid_dropped: got %0d expected 0", axi_viol); else n_pass++;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end
  initial begin
    n_chk = 0; n_pass = 0; areset = 1;
    req_valid_i = '0; req_we_i = '0; req_addr_i = '0; req_wdata_i = '0; req_wstrb_i = '0; rsp_ready_i = '0;
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0; bad_id = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; aw_hi = 0; w_only = 0; axi_viol = 0;
    last_awid = '0; last_arid = '0;
    for (int i = 0; i < NR; i++) model[i] = '0;
    test_reset;
    test_write_read;
    test_arbitration;
    test_out_of_range;
    test_wready_stall;
    test_rsp_stall;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/axi_reg_arbiter.md
# axi_reg_arbiter

Two-requester round-robin arbiter and AXI master sequencer in front of the `s_axi_reg` register slave. Each requester issues single-word read or write commands over a valid/ready request channel and receives a valid/ready response. The block serialises the commands onto one AXI master port as single-beat transactions (AW+W→B, AR→R). It returns read data and the response code to the owning requester.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `ID_W`, 4, AXI ID width
- `N_REGS`, 8, number of valid register addresses (0..N_REGS-1)
- `ID_BASE`, 0, AXI ID for requester 0; requester 1 uses ID_BASE+1

Ports:
- `clk` in 1: single clock.
- `areset` in 1: reset, synchronous, active-high.
- `req_valid_i` in [1:0]: command valid per requester.
- `req_ready_o` out [1:0]: command accepted.
- `req_we_i` in [1:0]: 1 = write.
- `req_addr_i` in [1:0][ADDR_W-1:0]: command address.
- `req_wdata_i` in [1:0][DATA_W-1:0]: write data.
- `req_wstrb_i` in [1:0][3:0]: byte strobes.
- `rsp_valid_o` out [1:0]: response valid.
- `rsp_ready_i` in [1:0]: response taken.
- `rsp_rdata_o` out DATA_W: read data, shared; qualified by `rsp_valid_o`.
- `rsp_resp_o` out 2: response code.
- Write address channel: `awid_o` out ID_W, `awaddr_o` out ADDR_W, `awvalid_o` out 1, `awready_i` in 1.
- Write data channel: `wid_o` out ID_W, `wdata_o` out DATA_W, `wstrb_o` out 4, `wlast_o` out 1, `wvalid_o` out 1, `wready_i` in 1.
- Write response channel: `bid_i` in ID_W, `bresp_i` in 2, `bvalid_i` in 1, `bready_o` out 1.
- Read address channel: `arid_o` out ID_W, `araddr_o` out ADDR_W, `arvalid_o` out 1, `arready_i` in 1.
- Read data channel: `rid_i` in ID_W, `rdata_i` in DATA_W, `rlast_i` in 1, `rvalid_i` in 1, `rready_o` out 1.

## Operation
- FSM states: IDLE, W_REQ, W_RESP, R_ADDR, R_DATA, RESP.
- **IDLE arbitration:**
  - `req_ready_o[k]` is asserted combinationally only in IDLE, for the granted k.
  - If both requesters are valid, the grant goes to the one not granted last.
  - If one is valid, it is granted.
  - `last_grant` resets to 1, so requester 0 wins the first contention.
- **Accept:** on accept, capture we/addr/wdata/wstrb, set `owner=k`, set `last_grant=k`.
- **Out-of-range address** (addr >= N_REGS): no AXI traffic. Go to RESP with resp 2'b10 (SLVERR) and rdata 0.
- **Write:** go to W_REQ.
  - `awvalid_o` and `wvalid_o` are raised together.
  - Each is dropped independently on its handshake; `aw_done`/`w_done` flags track completion.
  - When both are done, go to W_RESP with `bready_o`=1.
  - On `bvalid_i`: go to RESP. resp = `bresp_i`, or 2'b10 if `bid_i` ≠ the issued ID. rdata = 0.
- **Read:** go to R_ADDR with `arvalid_o`=1.
  - On the AR handshake, go to R_DATA with `rready_o`=1.
  - On `rvalid_i`: capture `rdata_i` and go to RESP. resp = 2'b00, or 2'b10 if `rid_i` ≠ the issued ID.
- **RESP:** `rsp_valid_o[owner]`=1, held with stable data until `rsp_ready_i[owner]`, then return to IDLE.
- **AXI IDs:** `awid_o`/`wid_o`/`arid_o` = ID_BASE+owner. `wlast_o` is constant 1. `rlast_i` is ignored.
- **AXI rule:** a valid is never dropped before its handshake.

## Timing
- Reset values: all valid/ready outputs 0 (except `req_ready_o`, which follows IDLE grant logic). aw/ar addr, wdata, wstrb, rsp_rdata, rsp_resp, and all IDs are 0. State is IDLE.
- Accept at cycle T → AXI valid(s) asserted at T+1 (registered).
- Response handshake at cycle U → `rsp_valid_o` at U+1.
- Out-of-range command accepted at T → `rsp_valid_o` at T+1.
- After the response handshake at V: IDLE at V+1; the next accept is possible at V+1.
- Best-case latencies with a zero-wait slave and immediate ready:
  - write: accept to rsp_valid = 3 cycles;
  - read: accept to rsp_valid = 3 cycles.
- AW and W handshakes may occur in the same cycle or in either order; both are tolerated.
- Requests arriving outside IDLE wait; `req_ready_o` stays 0.
- Reset mid-transaction: synchronous return to reset values next edge; the in-flight command is dropped with no response.

## Structure
- Package `axi_reg_arb_pkg`: state enum `arb_state_e`; resp constants `RESP_OKAY`=2'b00, `RESP_SLVERR`=2'b10.
- Sub-module `rr_arbiter_2`: 2-way round-robin pick from valids and `last_grant`; combinational grant plus registered pointer update on accept.

## Test plan
- Reset, then req0 write addr 3, data 0xDEADBEEF, strb 0xF → one AW/W with ID 0. rsp0 resp 0 at accept+3. A subsequent req0 read of addr 3 returns 0xDEADBEEF.
- req0 and req1 both valid in IDLE from reset → req0 granted first, req1 second. Repeat with both held valid → grants alternate 0,1,0,1.
- req1 read addr 8 with N_REGS=8 → no AR issued; rsp1 resp 2'b10 and rdata 0 at accept+1.
- Slave holds wready_i low 5 cycles after the AW handshake → awvalid_o drops after the AW handshake, wvalid_o stays high until wready_i, then one bready_o handshake and the response.
- rsp_ready_i held low 4 cycles → rsp_valid_o and rdata stay stable, no new grant. A mismatched bid_i forces resp 2'b10.
- areset asserted in W_RESP → all valids 0 next cycle, no response. After release, a req1 request is granted normally.
